// File: rtl/keypad_scanner_pkg.sv
// keypad_scanner_pkg: shared types and helpers for the 4x4 keypad scanner.
//   state_e       - scanner FSM states
//   key_code()    - maps a (row, column) position to its 4-bit key code
//   is_single()   - true when exactly one active-low row is asserted
//   low_row()     - index of the lowest asserted (low) row bit
//   col_index()   - index of the driven (low) column in a one-cold column word
package keypad_scanner_pkg;

    typedef enum logic [1:0] {
        StScan,
        StDebounce,
        StPressed,
        StRelease
    } state_e;

    // Layout: r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: E(*) 0 F(#) D
    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        unique case ({row, col})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hE;
            4'hD: code = 4'h0;
            4'hE: code = 4'hF;
            4'hF: code = 4'hD;
        endcase
        return code;
    endfunction

    function automatic logic is_single(input logic [3:0] rows_n);
        return $countones(~rows_n) == 1;
    endfunction

    function automatic logic [1:0] low_row(input logic [3:0] rows_n);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows_n[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    function automatic logic [1:0] col_index(input logic [3:0] col_n);
        logic [1:0] idx;
        case (col_n)
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: keypad-side and lock-side signals of the scanner.
//   row_in   - keypad rows, active-low, asynchronous to the scanner clock
//   col_out  - column drive, active-low, one bit low at a time
//   digit    - key code of the last accepted press
//   enter    - one-cycle strobe, digit valid in the same cycle
//   key_held - high from enter until the release is debounced
// master: the scanner itself; slave: keypad model / lock consumer.
interface keypad_scanner_if;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] digit;
    logic       enter;
    logic       key_held;

    modport master (
        input  row_in,
        output col_out,
        output digit,
        output enter,
        output key_held
    );

    modport slave (
        output row_in,
        input  col_out,
        input  digit,
        input  enter,
        input  key_held
    );
endinterface

// File: rtl/keypad_scanner_sync_2ff.sv
// keypad_scanner_sync_2ff: two-flop synchronizer for the 4 keypad rows.
//   clk      - system clock
//   reset    - asynchronous, active-high; resets to all rows released (4'b1111)
//   i_async  - raw rows
//   o_sync   - rows after two register stages
module keypad_scanner_sync_2ff (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] i_async,
    output logic [3:0] o_sync
);

    logic [3:0] r_meta;
    logic [3:0] r_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= 4'hF;
            r_sync <= 4'hF;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad front end. Rotates an active-low column
// drive once per scan tick, samples synchronized rows, debounces presses and
// releases, and emits one enter strobe with the key code per physical press.
//   clk    - system clock, rising edge
//   reset  - asynchronous, active-high
//   kp     - keypad_scanner_if.master (row_in, col_out, digit, enter, key_held)
// Parameters: SCAN_DIV clocks per scan tick (>=2), DEBOUNCE_SCANS agreeing
// ticks needed to accept a press or a release (>=1).
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 1000,
    parameter int unsigned DEBOUNCE_SCANS = 8
) (
    input  logic               clk,
    input  logic               reset,
    keypad_scanner_if.master   kp
);

    localparam int unsigned DivW = $clog2(SCAN_DIV);
    localparam int unsigned CntW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_SCANS);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    logic [3:0]      w_rows;
    logic [DivW-1:0] r_div;
    logic            w_tick;

    state_e          r_state, w_state_next;
    logic [CntW-1:0] r_cnt, w_cnt_next, w_cnt_inc;
    logic [1:0]      r_row, w_row_next;
    logic [3:0]      r_col_out, w_col_next, w_col_rot;
    logic [3:0]      r_digit, w_digit_next;
    logic            r_enter, w_enter_next;
    logic            r_held, w_held_next;
    logic            w_single, w_all_high;
    logic [1:0]      w_low_row;
    logic            w_accept, w_release_done;

    keypad_scanner_sync_2ff u_sync (
        .clk     (clk),
        .reset   (reset),
        .i_async (kp.row_in),
        .o_sync  (w_rows)
    );

    assign w_tick = (r_div == DivLast);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    assign w_single   = is_single(w_rows);
    assign w_low_row  = low_row(w_rows);
    assign w_all_high = (w_rows == 4'hF);
    assign w_col_rot  = {r_col_out[2:0], r_col_out[3]};
    // Saturate so the counter can never wrap even if the limit is missed.
    assign w_cnt_inc  = (r_cnt == CntLast) ? r_cnt : r_cnt + CntOne;

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_row_next     = r_row;
        w_col_next     = r_col_out;
        w_digit_next   = r_digit;
        w_enter_next   = 1'b0;
        w_held_next    = r_held;
        w_accept       = 1'b0;
        w_release_done = 1'b0;

        if (w_tick) begin
            unique case (r_state)
                StScan: begin
                    if (w_single) begin
                        w_row_next   = w_low_row;
                        w_cnt_next   = CntOne;
                        w_state_next = StDebounce;
                        w_accept     = (CntOne == CntLast);
                    end else begin
                        w_col_next = w_col_rot;
                    end
                end
                StDebounce: begin
                    if (w_single && (w_low_row == r_row)) begin
                        w_cnt_next = w_cnt_inc;
                        w_accept   = (w_cnt_inc == CntLast);
                    end else begin
                        w_state_next = StScan;
                        w_col_next   = w_col_rot;
                    end
                end
                StPressed: begin
                    // Any low row, including a second key in this column, counts as held.
                    if (w_all_high) begin
                        w_cnt_next     = CntOne;
                        w_state_next   = StRelease;
                        w_release_done = (CntOne == CntLast);
                    end
                end
                StRelease: begin
                    if (w_all_high) begin
                        w_cnt_next     = w_cnt_inc;
                        w_release_done = (w_cnt_inc == CntLast);
                    end else begin
                        w_state_next = StPressed;
                        w_cnt_next   = '0;
                    end
                end
                default: w_state_next = StScan;
            endcase
        end

        if (w_accept) begin
            w_state_next = StPressed;
            w_enter_next = 1'b1;
            w_digit_next = key_code(w_row_next, col_index(r_col_out));
            w_held_next  = 1'b1;
        end

        if (w_release_done) begin
            w_state_next = StScan;
            w_held_next  = 1'b0;
            w_col_next   = w_col_rot;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= StScan;
            r_cnt     <= '0;
            r_row     <= 2'd0;
            r_col_out <= 4'b1110;
            r_digit   <= 4'h0;
            r_enter   <= 1'b0;
            r_held    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_row     <= w_row_next;
            r_col_out <= w_col_next;
            r_digit   <= w_digit_next;
            r_enter   <= w_enter_next;
            r_held    <= w_held_next;
        end
    end

    assign kp.col_out  = r_col_out;
    assign kp.digit    = r_digit;
    assign kp.enter    = r_enter;
    assign kp.key_held = r_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: randomized and directed stimulus for keypad_scanner with
// a per-tick behavioural reference model and a physical keypad emulation.
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DS = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] keys_down;   // bit r*4+c: key at row r, column c is pressed

    int n_checks = 0;
    int n_errors = 0;
    int n_enter  = 0;
    int digits[$];

    always #5 clk = ~clk;

    keypad_scanner_if kp ();

    keypad_scanner #(
        .SCAN_DIV       (SD),
        .DEBOUNCE_SCANS (DS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .kp    (kp)
    );

    // A pressed key pulls its row low only while its column is driven low.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            kp.row_in[r] = ~|(keys_down[r*4 +: 4] & ~kp.col_out);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Mode: 0 scanning, 1 debouncing press, 2 held, 3 debouncing release.
    int code_tbl[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};
    int m_mode, m_col, m_row, m_cnt, m_div, m_nenter;
    logic [3:0] m_s1, m_s2, m_rows, m_digit;
    logic m_enter, m_held;

    task automatic model_tick(input logic [3:0] rows);
        int nlow;
        int lowr;
        nlow = 0;
        lowr = -1;
        for (int i = 0; i < 4; i++) begin
            if (!rows[i]) begin
                nlow++;
                if (lowr < 0) lowr = i;
            end
        end
        case (m_mode)
            0: if (nlow == 1) begin
                   m_row = lowr; m_cnt = 1; m_mode = 1;
               end else m_col = (m_col + 1) % 4;
            1: if (nlow == 1 && lowr == m_row) m_cnt++;
               else begin m_mode = 0; m_col = (m_col + 1) % 4; end
            2: if (rows == 4'hF) begin m_cnt = 1; m_mode = 3; end
            default: if (rows == 4'hF) m_cnt++;
                     else begin m_mode = 2; m_cnt = 0; end
        endcase
        if (m_mode == 1 && m_cnt >= DS) begin
            m_mode  = 2;
            m_enter = 1'b1;
            m_digit = 4'(code_tbl[m_row * 4 + m_col]);
            m_held  = 1'b1;
            m_nenter++;
        end else if (m_mode == 3 && m_cnt >= DS) begin
            m_mode = 0;
            m_held = 1'b0;
            m_col  = (m_col + 1) % 4;
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode = 0; m_col = 0; m_row = 0; m_cnt = 0; m_div = 0;
            m_s1 = 4'hF; m_s2 = 4'hF;
            m_digit = 4'h0; m_enter = 1'b0; m_held = 1'b0;
        end else begin
            m_rows  = m_s2;
            m_s2    = m_s1;
            m_s1    = kp.row_in;
            m_enter = 1'b0;
            if (m_div == SD - 1) begin
                m_div = 0;
                model_tick(m_rows);
            end else begin
                m_div++;
            end
        end
    end

    // Per-cycle comparison away from the active edge, plus enter bookkeeping.
    always @(negedge clk) begin
        check_eq("col_out", 32'(kp.col_out), 32'(4'(~(4'b0001 << m_col))));
        check_eq("digit", 32'(kp.digit), 32'(m_digit));
        check_eq("enter", 32'(kp.enter), 32'(m_enter));
        check_eq("key_held", 32'(kp.key_held), 32'(m_held));
        if (kp.enter === 1'b1) begin
            n_enter++;
            digits.push_back(int'(kp.digit));
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int idx, input int hold, input int rel);
        keys_down[idx] = 1'b1;
        wait_cycles(hold);
        keys_down[idx] = 1'b0;
        wait_cycles(rel);
    endtask

    int e0;
    logic [3:0] c0;
    int exp_seq[4] = '{4, 3, 2, 1};

    initial begin
        m_nenter  = 0;
        reset     = 1'b0;
        keys_down = '0;
        #1 reset = 1'b1;
        #1;
        check_eq("rst_col", 32'(kp.col_out), 32'h0000000E);
        check_eq("rst_digit", 32'(kp.digit), 32'h0);
        check_eq("rst_enter", 32'(kp.enter), 32'h0);
        check_eq("rst_held", 32'(kp.key_held), 32'h0);
        wait_cycles(3);
        reset = 1'b0;
        wait_cycles(10);

        // Stable '4' (row1, col0): one enter, digit 4, held until released.
        e0 = n_enter;
        keys_down[4] = 1'b1;
        wait_cycles(60);
        #1;
        check_eq("k4_enters", 32'(n_enter - e0), 32'd1);
        check_eq("k4_digit", 32'(kp.digit), 32'h4);
        check_eq("k4_held", 32'(kp.key_held), 32'd1);
        keys_down[4] = 1'b0;
        wait_cycles(40);
        #1;
        check_eq("k4_released", 32'(kp.key_held), 32'd0);

        // Bouncing '7' (row2, col0): never stable long enough.
        e0 = n_enter;
        repeat (12) begin
            keys_down[8] = 1'b1;
            wait_cycles(4);
            keys_down[8] = 1'b0;
            wait_cycles(4);
        end
        wait_cycles(8);
        #1;
        check_eq("bounce_enters", 32'(n_enter - e0), 32'd0);
        check_eq("bounce_held", 32'(kp.key_held), 32'd0);
        c0 = kp.col_out;
        wait_cycles(SD);
        #1;
        check_eq("bounce_rotate", 32'(kp.col_out != c0), 32'd1);

        // Long '#' hold, release, re-press.
        e0 = n_enter;
        keys_down[14] = 1'b1;
        wait_cycles(200);
        #1;
        check_eq("hash_enters", 32'(n_enter - e0), 32'd1);
        check_eq("hash_digit", 32'(kp.digit), 32'hF);
        keys_down[14] = 1'b0;
        wait_cycles(40);
        #1;
        check_eq("hash_released", 32'(kp.key_held), 32'd0);
        press(14, 60, 40);
        #1;
        check_eq("hash_repress", 32'(n_enter - e0), 32'd2);

        // Two rows low in column 1: never a single row.
        e0 = n_enter;
        keys_down[1] = 1'b1;
        keys_down[5] = 1'b1;
        wait_cycles(80);
        keys_down = '0;
        wait_cycles(10);
        #1;
        check_eq("multi_enters", 32'(n_enter - e0), 32'd0);

        // Reset while '5' is being debounced.
        keys_down[5] = 1'b1;
        for (int i = 0; i < 100 && m_mode != 1; i++) @(negedge clk);
        check_eq("reach_debounce", 32'(m_mode == 1), 32'd1);
        e0 = n_enter;
        #2 reset = 1'b1;
        #1;
        check_eq("midrst_col", 32'(kp.col_out), 32'h0000000E);
        check_eq("midrst_digit", 32'(kp.digit), 32'h0);
        check_eq("midrst_enter", 32'(kp.enter), 32'h0);
        check_eq("midrst_held", 32'(kp.key_held), 32'h0);
        @(negedge clk);
        keys_down[5] = 1'b0;
        reset = 1'b0;
        wait_cycles(30);
        #1;
        check_eq("midrst_noenter", 32'(n_enter - e0), 32'd0);

        // Code sequence 4,3,2,1 as a lock would receive it.
        digits.delete();
        press(4, 60, 40);
        press(2, 60, 40);
        press(1, 60, 40);
        press(0, 60, 40);
        #1;
        check_eq("seq_count", 32'(digits.size()), 32'd4);
        for (int i = 0; i < 4 && i < digits.size(); i++) begin
            check_eq("seq_digit", 32'(digits[i]), 32'(exp_seq[i]));
        end

        // Randomized presses, bounces and chords against the model.
        repeat (40) begin
            int kind;
            int k1;
            kind = int'($urandom_range(0, 3));
            k1   = int'($urandom_range(0, 15));
            case (kind)
                0: press(k1, int'($urandom_range(5, 120)), int'($urandom_range(5, 50)));
                1: begin
                    repeat (int'($urandom_range(2, 8))) begin
                        keys_down[k1] = 1'b1;
                        wait_cycles(int'($urandom_range(1, 10)));
                        keys_down[k1] = 1'b0;
                        wait_cycles(int'($urandom_range(1, 10)));
                    end
                end
                2: begin
                    keys_down[k1] = 1'b1;
                    wait_cycles(int'($urandom_range(0, 30)));
                    keys_down[$urandom_range(0, 15)] = 1'b1;
                    wait_cycles(int'($urandom_range(10, 80)));
                    keys_down = '0;
                    wait_cycles(int'($urandom_range(5, 50)));
                end
                default: wait_cycles(int'($urandom_range(1, 40)));
            endcase
        end
        keys_down = '0;
        wait_cycles(40);
        #1;
        check_eq("enter_total", 32'(n_enter), 32'(m_nenter));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
